// File: rtl/maxpool_window_sequencer.sv
// maxpool_window_sequencer: turns a row-major pixel stream into non-overlapping
// STRIDE_SIZE x STRIDE_SIZE windows packed for the maxpool datapath.
// Earlier rows of a window group sit in a line buffer. The pixels seen so far in
// the last row of the group sit in a short shift register.
// Optional feature macro: MAXPOOL_SEQ_WINDOW_COUNT_EN adds the window_count output.
module maxpool_window_sequencer #(
    parameter int unsigned STRIDE_SIZE = 2,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ROW_SIZE    = 4,
    parameter int unsigned COLUMN_SIZE = 4
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic [DATA_WIDTH-1:0]                     pixel_in,
    input  logic                                      pixel_valid,
    output logic                                      pixel_ready,
    output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
    output logic                                      window_valid,
    input  logic                                      window_ready,
    output logic                                      busy,
    output logic                                      frame_done
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
    ,
    output logic [$clog2((ROW_SIZE/STRIDE_SIZE)*(COLUMN_SIZE/STRIDE_SIZE)+1)-1:0] window_count
`endif
);

    localparam int unsigned S          = STRIDE_SIZE;
    localparam int unsigned DW         = DATA_WIDTH;
    localparam int unsigned CW         = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int unsigned RW         = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int unsigned PW         = $clog2(S);
    localparam int unsigned VALID_COLS = (ROW_SIZE / S) * S;
    localparam int unsigned VALID_ROWS = (COLUMN_SIZE / S) * S;

    localparam logic [CW:0]   VALID_COLS_W = (CW+1)'(VALID_COLS);
    localparam logic [RW:0]   VALID_ROWS_W = (RW+1)'(VALID_ROWS);
    localparam logic [CW-1:0] LAST_COL     = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(COLUMN_SIZE - 1);
    localparam logic [PW-1:0] LAST_PH      = PW'(S - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

    state_t            state;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [PW-1:0]     col_ph;   // col_cnt % S, kept as its own counter
    logic [PW-1:0]     row_ph;   // row_cnt % S
    logic [DW-1:0]     line_buf [S-1][ROW_SIZE];
    logic [DW-1:0]     shift_reg [S-1];
    logic [S*S*DW-1:0] window_next;

    logic accept, in_region, last_row_of_group, last_col_of_group, emit, last_pixel;

    assign pixel_ready       = (state == StRun) && (!window_valid || window_ready);
    assign accept            = pixel_valid && pixel_ready;
    assign in_region         = ({1'b0, col_cnt} < VALID_COLS_W) && ({1'b0, row_cnt} < VALID_ROWS_W);
    assign last_row_of_group = (row_ph == LAST_PH);
    assign last_col_of_group = (col_ph == LAST_PH);
    assign emit              = accept && in_region && last_row_of_group && last_col_of_group;
    assign last_pixel        = (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);

    // Assemble the window that completes with the current pixel
    always_comb begin
        window_next = '0;
        for (int r = 0; r < int'(S) - 1; r++) begin
            for (int c = 0; c < int'(S); c++) begin
                window_next[(r*S+c)*DW +: DW] = line_buf[r][col_cnt - CW'(int'(S) - 1 - c)];
            end
        end
        for (int c = 0; c < int'(S) - 1; c++) begin
            window_next[((S-1)*S+c)*DW +: DW] = shift_reg[c];
        end
        window_next[(S*S-1)*DW +: DW] = pixel_in;
    end

    // Pixel storage: line buffer for early rows, shift register for the last row
    always_ff @(posedge clock) begin
        if (accept && in_region) begin
            if (!last_row_of_group) begin
                for (int r = 0; r < int'(S) - 1; r++) begin
                    if (row_ph == PW'(r)) line_buf[r][col_cnt] <= pixel_in;
                end
            end else begin
                for (int i = 0; i < int'(S) - 2; i++) shift_reg[i] <= shift_reg[i+1];
                shift_reg[S-2] <= pixel_in;
            end
        end
    end

    // Frame FSM, raster counters and registered window/status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            col_cnt      <= '0;
            row_cnt      <= '0;
            col_ph       <= '0;
            row_ph       <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
            window_count <= '0;
`endif
        end else begin
            // A new window may replace the accepted one in the same cycle, with no bubble
            if (emit) begin
                window_out   <= window_next;
                window_valid <= 1'b1;
            end else if (window_valid && window_ready) begin
                window_valid <= 1'b0;
            end
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
            if (window_valid && window_ready) window_count <= window_count + 1'b1;
`endif
            case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StRun;
                        busy    <= 1'b1;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        col_ph  <= '0;
                        row_ph  <= '0;
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
                        window_count <= '0;
`endif
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            col_ph  <= '0;
                            row_ph  <= last_row_of_group ? '0 : row_ph + 1'b1;
                            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                            col_ph  <= last_col_of_group ? '0 : col_ph + 1'b1;
                        end
                        if (last_pixel) state <= StFlush;
                    end
                end
                StFlush: begin
                    if (!window_valid || window_ready) begin
                        state      <= StDone;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Randomized bench for maxpool_window_sequencer. A 4x4 and a 5x5 instance share
// their inputs; sel picks the one that is started and observed. Expected windows
// come straight from the frame image; cycle behaviour comes from a small frame model.
module tb_maxpool_window_sequencer;

    localparam int S  = 2;
    localparam int DW = 16;
    localparam int WW = S * S * DW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          window_ready = 1'b1;
    bit            sel = 1'b0;

    logic          pr4, wv4, busy4, fd4, pr5, wv5, busy5, fd5;
    logic [WW-1:0] wo4, wo5;
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
    logic [2:0]    wc4, wc5;
`endif

    always #5 clock = ~clock;

    maxpool_window_sequencer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(4), .COLUMN_SIZE(4))
    dut4 (
        .clock(clock), .reset_n(reset_n), .start(start && !sel), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(pr4), .window_out(wo4), .window_valid(wv4),
        .window_ready(window_ready), .busy(busy4), .frame_done(fd4)
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
        , .window_count(wc4)
`endif
    );

    maxpool_window_sequencer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(5), .COLUMN_SIZE(5))
    dut5 (
        .clock(clock), .reset_n(reset_n), .start(start && sel), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(pr5), .window_out(wo5), .window_valid(wv5),
        .window_ready(window_ready), .busy(busy5), .frame_done(fd5)
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
        , .window_count(wc5)
`endif
    );

    logic          pr, wv, busy, fd;
    logic [WW-1:0] wo;
    assign pr   = sel ? pr5 : pr4;
    assign wv   = sel ? wv5 : wv4;
    assign busy = sel ? busy5 : busy4;
    assign fd   = sel ? fd5 : fd4;
    assign wo   = sel ? wo5 : wo4;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame image and the windows it must produce, in emission order
    logic [DW-1:0] frame [0:24];
    logic [WW-1:0] exp_win [0:15];
    int cur_cols, cur_rows, n_pix, n_win;

    function automatic void build_expected();
        logic [WW-1:0] w;
        int wcols, wrows;
        wcols = cur_cols / S;
        wrows = cur_rows / S;
        n_pix = cur_cols * cur_rows;
        n_win = wcols * wrows;
        for (int wr = 0; wr < wrows; wr++) begin
            for (int wc = 0; wc < wcols; wc++) begin
                w = '0;
                for (int r = 0; r < S; r++)
                    for (int c = 0; c < S; c++)
                        w[(r*S+c)*DW +: DW] = frame[(wr*S+r)*cur_cols + wc*S + c];
                exp_win[wr*wcols+wc] = w;
            end
        end
    endfunction

    // Frame-level model state, advanced once per cycle at the falling edge
    bit m_active, m_run, m_flush, m_fd, nxt_fd;
    int acc_cnt, trig_cnt, hs_cnt, fd_cnt = 0;
    int mrow, mcol;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_active = 0; m_run = 0; m_flush = 0; m_fd = 0;
            acc_cnt = 0; trig_cnt = 0; hs_cnt = 0;
        end else begin
            check_eq("pixel_ready", pr, m_run && (!wv || window_ready));
            check_eq("window_valid", wv, trig_cnt > hs_cnt);
            if (wv) begin
                if (hs_cnt < n_win) check_eq("window_out", wo, exp_win[hs_cnt]);
                else check_eq("window_extra", 1'b1, 1'b0);
            end
            check_eq("busy", busy, m_run || m_flush);
            check_eq("frame_done", fd, m_fd);
            if (fd) begin
                check_eq("win_total", hs_cnt, n_win);
`ifdef MAXPOOL_SEQ_WINDOW_COUNT_EN
                check_eq("window_count", sel ? wc5 : wc4, n_win);
`endif
            end
            nxt_fd = 0;
            if (m_flush && (!wv || window_ready)) begin
                m_flush = 0;
                nxt_fd  = 1;
            end
            if (wv && window_ready) hs_cnt++;
            if (pixel_valid && pr) begin
                mrow = acc_cnt / cur_cols;
                mcol = acc_cnt % cur_cols;
                if (mrow < (cur_rows / S) * S && mcol < (cur_cols / S) * S &&
                    mrow % S == S - 1 && mcol % S == S - 1) trig_cnt++;
                acc_cnt++;
                if (acc_cnt == n_pix) begin
                    m_run   = 0;
                    m_flush = 1;
                end
            end
            if (start && !m_active) begin
                m_active = 1; m_run = 1;
                acc_cnt = 0; trig_cnt = 0; hs_cnt = 0;
            end
            if (m_fd) begin
                m_active = 0;
                fd_cnt++;
            end
            m_fd = nxt_fd;
        end
    end

    // window_ready policy: 0 always high, 1 random, 2 low for 5 cycles after first window
    int rmode = 0;
    bit seen_wv;
    int stall;

    task automatic cycle(output bit accepted);
        case (rmode)
            0: window_ready = 1'b1;
            1: window_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!seen_wv && wv) begin
                    seen_wv = 1;
                    stall   = 5;
                end
                if (stall > 0) begin
                    window_ready = 1'b0;
                    stall--;
                end else begin
                    window_ready = 1'b1;
                end
            end
        endcase
        @(negedge clock);
        accepted = pixel_valid && pr;
        @(posedge clock);
        #1;
    endtask

    // Stream one frame; rst_at > 0 resets once that many pixels are accepted
    task automatic run_frame(input bit sel_v, input int rm, input bit vrand,
                             input bit start_mid, input int rst_at);
        bit acc;
        int k, guard, fd0;
        rmode   = rm;
        seen_wv = 0;
        stall   = 0;
        // Idle pixels must be ignored
        pixel_valid = 1'b1;
        pixel_in    = 16'hdead;
        cycle(acc);
        cycle(acc);
        start = 1'b1;
        cycle(acc);
        start = 1'b0;
        k = 0;
        guard = 0;
        while (k < n_pix && guard < 3000) begin
            pixel_in    = frame[k];
            pixel_valid = vrand ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            start       = start_mid && (k == 8);
            cycle(acc);
            if (acc) k++;
            guard++;
            if (rst_at > 0 && k == rst_at) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                check_eq("rst_window_valid", wv, 1'b0);
                check_eq("rst_busy", busy, 1'b0);
                check_eq("rst_pixel_ready", pr, 1'b0);
                pixel_valid = 1'b0;
                @(negedge clock);
                @(posedge clock);
                #1;
                reset_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        if (k < n_pix) check_eq("pixel_timeout", k, n_pix);
        pixel_valid = 1'b0;
        fd0 = fd_cnt;
        guard = 0;
        while (fd_cnt == fd0 && guard < 200) begin
            cycle(acc);
            guard++;
        end
        if (fd_cnt == fd0) check_eq("frame_done_timeout", fd_cnt, fd0 + 1);
        cycle(acc);
    endtask

    task automatic setup(input bit sel_v, input int kind);
        sel = sel_v;
        cur_cols = sel_v ? 5 : 4;
        cur_rows = sel_v ? 5 : 4;
        for (int i = 0; i < cur_cols * cur_rows; i++) begin
            case (kind)
                0: frame[i] = DW'((i / cur_cols) * 4 + (i % cur_cols));
                1: frame[i] = 16'hffff;
                default: frame[i] = DW'($urandom);
            endcase
        end
        build_expected();
    endtask

    initial begin
        #2;
        check_eq("reset_window_valid", wv4, 1'b0);
        check_eq("reset_window_out", wo4, '0);
        check_eq("reset_busy", busy4, 1'b0);
        check_eq("reset_frame_done", fd4, 1'b0);
        check_eq("reset_pixel_ready", pr4, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        setup(0, 0); run_frame(0, 0, 0, 0, 0);   // reference frame, continuous
        setup(0, 0); run_frame(0, 2, 0, 0, 0);   // downstream stall after first window
        setup(1, 2); run_frame(1, 1, 1, 0, 0);   // 5x5 with discarded edge pixels
        setup(0, 1); run_frame(0, 1, 1, 0, 0);   // all-ones data
        setup(0, 0); run_frame(0, 0, 0, 0, 7);   // reset after pixel 6
        setup(0, 0); run_frame(0, 0, 0, 1, 0);   // restart frame, start pulsed mid-run
        for (int i = 0; i < 3; i++) begin
            setup(0, 2); run_frame(0, 1, 1, 1, 0);
            setup(1, 2); run_frame(1, 1, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_window_sequencer.md
Name: maxpool_window_sequencer

Overview:
- Converts a raster pixel stream (one pixel per accepted beat, row-major) into non-overlapping STRIDE_SIZE x STRIDE_SIZE windows.
- Windows are packed in the exact data_in layout the maxpool datapath consumes.
- Buffers STRIDE_SIZE-1 rows in a line buffer and tracks frame position.
- Applies ready/valid backpressure upstream, and sequences frames via start / frame_done.

Parameters:
- STRIDE_SIZE, 2: window edge and stride. Must be >= 2.
- DATA_WIDTH, 16: pixel width in bits.
- ROW_SIZE, 4: pixels per image row.
- COLUMN_SIZE, 4: rows per frame.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  arms one frame. Honoured only in IDLE.
- pixel_in  in  DATA_WIDTH  raster pixel.
- pixel_valid  in  1  pixel_in valid.
- pixel_ready  out  1  pixel accepted when pixel_valid && pixel_ready.
- window_out  out  STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH  packed window.
- window_valid  out  1  window_out valid. Held until accepted.
- window_ready  in  1  downstream accept.
- busy  out  1  high in RUN or FLUSH.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 and state goes to IDLE.
  - Counters, line buffer write pointer and window register are cleared.
  - Line buffer contents need not be cleared.
- Window packing: element (r,c), with r = row within window and c = column within window, occupies slot idx = r*STRIDE_SIZE+c at bits [(idx+1)*DATA_WIDTH-1 : idx*DATA_WIDTH].
- Counters: col_cnt 0..ROW_SIZE-1 and row_cnt 0..COLUMN_SIZE-1 advance on each accepted pixel. col_cnt wraps into row_cnt.
- Valid region:
  - VALID_COLS = (ROW_SIZE/STRIDE_SIZE)*STRIDE_SIZE; VALID_ROWS likewise from COLUMN_SIZE.
  - Pixels with col_cnt >= VALID_COLS or row_cnt >= VALID_ROWS are accepted and discarded.
- Storage:
  - Pixels in rows with row_cnt%STRIDE_SIZE < STRIDE_SIZE-1 are written to line buffer slot [row_cnt%STRIDE_SIZE][col_cnt].
  - In the last row of a group, the current row's previous STRIDE_SIZE-1 pixels are held in a shift register.
- Emission:
  - Trigger: an accepted pixel at the last row of a group with col_cnt%STRIDE_SIZE == STRIDE_SIZE-1 completes a window.
  - Latency: window_out and window_valid load on that same clock edge, i.e. visible in the next cycle (latency 1).
- Handshake:
  - pixel_ready = (state==RUN) && (!window_valid || window_ready).
  - window_valid clears on acceptance unless a new window loads in the same cycle; in that case it stays high with new data, with no bubble.
  - window_out is stable while window_valid && !window_ready.
- FSM:
  - IDLE: pixel_ready=0. start -> RUN; counters are zeroed on entry.
  - RUN: on acceptance of pixel (COLUMN_SIZE-1, ROW_SIZE-1) -> FLUSH.
  - FLUSH: pixel_ready=0. When !window_valid, or window_valid && window_ready -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- pixel_valid in IDLE is ignored; no counter movement.
- Reset mid-frame: immediate return to IDLE, window_valid=0, partial window discarded.

Optional Feature:
- Macro: MAXPOOL_SEQ_WINDOW_COUNT_EN.
- When defined:
  - Adds output port window_count (width $clog2((ROW_SIZE/STRIDE_SIZE)*(COLUMN_SIZE/STRIDE_SIZE)+1)).
  - Increments on each window handshake; reset to 0 by reset_n and on IDLE->RUN.
  - Holds its final value after frame_done until the next start.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- 4x4, STRIDE 2, window_ready=1, pixel value = row*4+col streamed continuously:
  - 4 windows, with window_out = 0x0005_0004_0001_0000, 0x0007_0006_0003_0002, 0x000D_000C_0009_0008, 0x000F_000E_000B_000A.
  - Each window appears one cycle after pixel 5, 7, 13, 15 respectively.
  - frame_done pulses 2 cycles after pixel 15 is accepted.
- Same frame with window_ready=0 for 5 cycles after the first window_valid:
  - pixel_ready drops only once window_valid is high.
  - window_out holds 0x0005_0004_0001_0000.
  - No pixel is lost; window sequence is unchanged.
- ROW_SIZE=5, COLUMN_SIZE=5, STRIDE 2:
  - Exactly 4 windows; column 4 and row 4 pixels are discarded.
  - FSM reaches DONE after all 25 pixels are accepted.
- Signed data 0xFFFF (-1) in all pixels: windows carry 0xFFFF in every slot, unmodified.
- Assert reset_n low after pixel 6, then restart with start:
  - window_valid=0 and busy=0 immediately (async).
  - The next frame produces the correct first window 0x0005_0004_0001_0000.
- start pulsed during RUN: no counter reset and no change in window sequence.
- With MAXPOOL_SEQ_WINDOW_COUNT_EN defined: window_count reads 4 at frame_done.
